udma_wrr_arbiter: RTL and testbench
===================================

UDMA_WRR_ARBITER -- requirements
Module: udma_wrr_arbiter

Interface
REQ-001: Parameter N, default 9, SHALL set the number of requesters (rx channels plus the filter channel).
REQ-002: Parameter S, default $clog2(N), SHALL set the grant index width.
REQ-003: Parameter WEIGHT_W, default 4, SHALL set the per-requester weight width.
REQ-004: clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rstn_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: clr_i  input  1  SHALL be a synchronous arbitration-state clear.
REQ-007: req_i  input  N  SHALL carry the per-requester request bits.
REQ-008: cfg_weight_i  input  N x WEIGHT_W  SHALL carry the burst weight of each requester (grants per ownership).
REQ-009: grant_ack_i  input  1  SHALL indicate that the consumer sampled the current grant (datapath not stalled).
REQ-010: grant_o  output  N  SHALL carry the one-hot combinational grant.
REQ-011: grant_idx_o  output  S  SHALL carry the binary index of the granted requester (0 when none).
REQ-012: anygrant_o  output  1  SHALL be the OR of grant_o.
REQ-013: burst_last_o  output  1  SHALL flag that the current grant, if acked, exhausts the owner's credit.

Function
REQ-014: State SHALL be r_ptr (S bits, current owner) and r_credit (WEIGHT_W bits, remaining grants for the owner).
REQ-015: Effective weight SHALL be max(cfg_weight_i[k],1); weight 0 behaves as 1.
REQ-016: If r_credit>0 and req_i[r_ptr]=1, grant SHALL go to r_ptr (burst continuation).
REQ-017: Otherwise, grant SHALL go to the first requester with req_i set, searching r_ptr+1, r_ptr+2, ... wrapping modulo N, r_ptr last.
REQ-018: With req_i all zero, grant_o SHALL be 0, anygrant_o 0, grant_idx_o 0, burst_last_o 0.
REQ-019: grant_o SHALL be purely combinational from req_i, r_ptr and r_credit; zero-cycle request-to-grant latency.
REQ-020: State SHALL change only on a cycle with grant_ack_i=1 and anygrant_o=1; otherwise, the grant SHALL remain stable while req_i is stable.
REQ-021: On ack of continuation grant (REQ-016), r_credit SHALL decrement by 1; r_ptr is unchanged.
REQ-022: On ack of new-owner grant k (REQ-017), r_ptr SHALL load k and r_credit SHALL load effective_weight(k)-1.
REQ-023: burst_last_o SHALL be 1 when the continuation grant has r_credit=1, or the new-owner grant has effective weight 1.
REQ-024: If the owner drops req_i with r_credit>0, the remaining credit SHALL be forfeited; the next grant follows REQ-017.
REQ-025: cfg_weight_i changes SHALL take effect only on the next new-owner load; in-flight credit is not altered.
REQ-026: grant_ack_i with anygrant_o=0 SHALL be ignored.
REQ-027: clr_i=1 SHALL set r_ptr=N-1 and r_credit=0 at the next edge, overriding any concurrent ack; grant_o in that cycle remains combinational from pre-clear state.
REQ-028: Indices >= N SHALL never appear on grant_idx_o; wrap arithmetic SHALL be modulo N, not 2^S.

Reset
REQ-029: While rstn_i=0, r_ptr SHALL be N-1 and r_credit 0, so the first search starts at requester 0.
REQ-030: Reset values of outputs SHALL follow from this state: grant_o=0 unless req_i is set; anygrant_o, grant_idx_o and burst_last_o per REQ-017/018/023.
REQ-031: Reset asserted mid-burst SHALL drop all credit; after release, arbitration restarts from requester 0.

Verification
REQ-032: After reset, req_i=9'h1FF, all weights 1, ack every cycle -> grant_idx_o sequence 0,1,...,8,0; burst_last_o=1 each cycle.
REQ-033: weights[2]=3, others 1, req_i=9'b000000101, ack every cycle -> grant_idx_o 0,2,2,2,0,2,2,2; burst_last_o=1 on 0 and on third 2.
REQ-034: Grant to 2 with weight 3, hold grant_ack_i=0 for 5 cycles -> grant_o=9'h004 stable, r_credit unchanged; then ack -> credit decrements once.
REQ-035: Owner 2 mid-burst (credit 2) drops req, req_i[5]=1 -> next grant 5; later req 2 returns -> new grant with credit reloaded to 2.
REQ-036: weight 0 on requester 4 alone -> single grant per ownership, burst_last_o=1; clr_i pulse with ack -> next search starts at 0.
REQ-037: rstn_i asserted mid-burst of requester 7 -> after release with req_i=9'h180, first grant is 7 with full fresh credit.

Source files
------------

// File: rtl/udma_wrr_arbiter.sv
// udma_wrr_arbiter: weighted round-robin arbiter with per-owner burst credit
// and a combinational one-hot grant.
module udma_wrr_arbiter #(
    parameter int N        = 9,
    parameter int S        = $clog2(N),
    parameter int WEIGHT_W = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          clr_i,
    input  logic [N-1:0]                  req_i,
    input  logic [N-1:0][WEIGHT_W-1:0]    cfg_weight_i,
    input  logic                          grant_ack_i,
    output logic [N-1:0]                  grant_o,
    output logic [S-1:0]                  grant_idx_o,
    output logic                          anygrant_o,
    output logic                          burst_last_o
);
    logic [S-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [S:0]          idx_w;
    logic [S-1:0]        new_idx;
    logic                found;
    logic                cont;
    logic [WEIGHT_W-1:0] new_w;
    logic [WEIGHT_W-1:0] eff_w;

    assign cont = (credit_q != '0) && req_i[ptr_q];

    // Search starts just after the owner and wraps modulo N, owner last.
    always_comb begin
        found   = 1'b0;
        new_idx = '0;
        idx_w   = '0;
        for (int i = 1; i <= N; i++) begin
            idx_w = (S+1)'(ptr_q) + (S+1)'(i);
            idx_w = (idx_w >= (S+1)'(N)) ? idx_w - (S+1)'(N) : idx_w;
            if (!found && req_i[idx_w[S-1:0]]) begin
                found   = 1'b1;
                new_idx = idx_w[S-1:0];
            end
        end
    end

    assign new_w        = cfg_weight_i[new_idx];
    assign eff_w        = (new_w == '0) ? WEIGHT_W'(1) : new_w;
    assign anygrant_o   = cont | found;
    assign grant_idx_o  = cont ? ptr_q : (found ? new_idx : '0);
    assign grant_o      = anygrant_o ? (N'(1) << grant_idx_o) : '0;
    assign burst_last_o = cont ? (credit_q == WEIGHT_W'(1)) : (found && eff_w == WEIGHT_W'(1));

    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        if (clr_i) begin
            ptr_d    = S'(N-1);
            credit_d = '0;
        end else if (grant_ack_i && anygrant_o) begin
            ptr_d    = cont ? ptr_q : new_idx;
            credit_d = cont ? credit_q - WEIGHT_W'(1) : eff_w - WEIGHT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q    <= S'(N-1);
            credit_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end
endmodule

// File: tb/tb_udma_wrr_arbiter.sv
// tb_udma_wrr_arbiter: directed and random stimulus checked against a
// behavioural owner/credit model of the weighted round-robin rules.
module tb_udma_wrr_arbiter;
    localparam int N = 9;
    localparam int S = 4;
    localparam int W = 4;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic               clr_i;
    logic [N-1:0]       req_i;
    logic [N-1:0][W-1:0] cfg_w;
    logic               grant_ack_i;
    logic [N-1:0]       grant_o;
    logic [S-1:0]       grant_idx_o;
    logic               anygrant_o;
    logic               burst_last_o;

    int passed = 0;
    int total  = 0;
    int m_ptr;
    int m_credit;
    int e_idx;
    bit e_any, e_cont, e_last;

    udma_wrr_arbiter #(.N(N), .S(S), .WEIGHT_W(W)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .clr_i        (clr_i),
        .req_i        (req_i),
        .cfg_weight_i (cfg_w),
        .grant_ack_i  (grant_ack_i),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o),
        .anygrant_o   (anygrant_o),
        .burst_last_o (burst_last_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int eff(input int k);
        return (cfg_w[k] == 0) ? 1 : int'(cfg_w[k]);
    endfunction

    function automatic void model();
        int j;
        e_cont = (m_credit > 0) && req_i[m_ptr];
        e_any  = 1'b0;
        e_idx  = 0;
        e_last = 1'b0;
        if (e_cont) begin
            e_any  = 1'b1;
            e_idx  = m_ptr;
            e_last = (m_credit == 1);
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (!e_any && req_i[j]) begin
                    e_any  = 1'b1;
                    e_idx  = j;
                    e_last = (eff(j) == 1);
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        model();
        eg = e_any ? (N'(1) << e_idx) : '0;
        chk("grant_o", int'(grant_o), int'(eg));
        chk("grant_idx_o", int'(grant_idx_o), e_idx);
        chk("anygrant_o", int'(anygrant_o), int'(e_any));
        chk("burst_last_o", int'(burst_last_o), int'(e_last));
    endtask

    task automatic step(input logic [N-1:0] r, input logic a, input logic c);
        req_i = r;
        grant_ack_i = a;
        clr_i = c;
        #1;
        check_outputs();
        @(posedge clk_i);
        if (c) begin
            m_ptr = N - 1;
            m_credit = 0;
        end else if (a && e_any) begin
            if (e_cont) m_credit--;
            else begin
                m_ptr = e_idx;
                m_credit = eff(e_idx) - 1;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        int seq33 [8] = '{0, 2, 2, 2, 0, 2, 2, 2};
        logic [N-1:0] r;
        rstn_i = 1'b0; clr_i = 1'b0; grant_ack_i = 1'b0; req_i = '0;
        for (int k = 0; k < N; k++) cfg_w[k] = W'(1);
        m_ptr = N - 1; m_credit = 0;
        @(negedge clk_i); #1;
        check_outputs();
        chk("reset_any", int'(anygrant_o), 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Equal weights, everyone requesting: plain rotation from 0
        for (int i = 0; i < 10; i++) begin
            step(9'h1FF, 1'b1, 1'b0);
            chk("rr_idx", e_idx, i % N);
            chk("rr_last", int'(e_last), 1);
        end

        step('0, 1'b0, 1'b1);
        cfg_w[2] = W'(3);
        for (int i = 0; i < 8; i++) begin
            step(9'h005, 1'b1, 1'b0);
            chk("w3_idx", e_idx, seq33[i]);
            chk("w3_last", int'(e_last), int'(i == 0 || i == 3 || i == 4 || i == 7));
        end

        // Stall: grant must hold while ack is low
        step('0, 1'b0, 1'b1);
        step(9'h004, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(9'h004, 1'b0, 1'b0);
            chk("stall_grant", int'(grant_o), 'h004);
        end
        step(9'h004, 1'b1, 1'b0);
        step(9'h004, 1'b0, 1'b0);
        chk("stall_last", int'(burst_last_o), 1);

        // Forfeit credit when owner drops request
        step('0, 1'b0, 1'b1);
        step(9'h004, 1'b1, 1'b0);
        step(9'h020, 1'b1, 1'b0);
        chk("forfeit_idx", e_idx, 5);
        step(9'h004, 1'b1, 1'b0);
        step(9'h004, 1'b1, 1'b0);
        chk("reload_last0", int'(e_last), 0);
        step(9'h004, 1'b1, 1'b0);
        chk("reload_last1", int'(e_last), 1);

        cfg_w[4] = W'(0);
        for (int i = 0; i < 3; i++) begin
            step(9'h010, 1'b1, 1'b0);
            chk("w0_idx", e_idx, 4);
            chk("w0_last", int'(e_last), 1);
        end
        step(9'h011, 1'b1, 1'b1);
        step(9'h011, 1'b1, 1'b0);
        chk("clr_restart", e_idx, 0);

        // Async reset in the middle of requester 7's burst
        cfg_w[7] = W'(4);
        step('0, 1'b0, 1'b1);
        step(9'h080, 1'b1, 1'b0);
        step(9'h080, 1'b1, 1'b0);
        req_i = 9'h180; grant_ack_i = 1'b1;
        #2 rstn_i = 1'b0;
        m_ptr = N - 1; m_credit = 0;
        #1;
        check_outputs();
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(9'h180, 1'b1, 1'b0);
            chk("rst_burst_idx", e_idx, (i < 4) ? 7 : 8);
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) cfg_w[$urandom_range(0, N - 1)] = W'($urandom_range(0, 15));
            r = N'($urandom) & N'($urandom);
            step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
